// File: rtl/cb_obi_arb_pkg.sv
// Width helpers and ID type for the round-robin OBI arbiter and its ID FIFO.
package cb_obi_arb_pkg;

  localparam int unsigned DEFAULT_NMASTER         = 3;
  localparam int unsigned DEFAULT_MAX_OUTSTANDING = 2;

  // An ID must hold a master index; a 2-master system still needs one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return ($clog2(n) > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  localparam int unsigned CB_OBI_ID_W  = id_width(DEFAULT_NMASTER);
  localparam int unsigned CB_OBI_CNT_W = cnt_width(DEFAULT_MAX_OUTSTANDING);

  typedef logic [CB_OBI_ID_W-1:0] cb_obi_id_t;

endpackage

// File: rtl/obi_pkg.sv
// OBI bus request/response types shared by the X-HEEP external master ports.
package obi_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/cb_id_fifo.sv
// Small synchronous FIFO holding the master index of each granted, not yet
// answered transaction; pointers wrap modulo DEPTH (any depth >= 1).
module cb_id_fifo
  import cb_obi_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          push_i,
  input  logic                          pop_i,
  input  logic [WIDTH-1:0]              data_i,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [WIDTH-1:0]              head_o,
  output logic [$clog2(DEPTH+1)-1:0]    count_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = cnt_width(DEPTH);

  typedef logic [PtrW-1:0] ptr_t;

  logic [WIDTH-1:0] mem_q [DEPTH];
  ptr_t             wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  function automatic ptr_t wrap_inc(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wrap_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= wrap_inc(rd_ptr_q);
      count_q <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; an entry is only read
  // after it has been written, and a reset-free array maps to plain RAM/flops.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/cb_obi_rr_arbiter.sv
// Round-robin N-to-1 OBI arbiter: serialises master requests onto one slave
// port and routes each rvalid/rdata back to its issuer through an ID FIFO.
module cb_obi_rr_arbiter
  import obi_pkg::*;
  import cb_obi_arb_pkg::*;
#(
  parameter int NMASTER         = 3,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  obi_req_t                            master_req_i  [NMASTER],
  output obi_resp_t                           master_resp_o [NMASTER],
  output obi_req_t                            slave_req_o,
  input  obi_resp_t                           slave_resp_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
  output logic                                err_o
);

  localparam int unsigned IdW = id_width(NMASTER);

  typedef logic [IdW-1:0] id_t;

  id_t  rr_ptr_q, rr_ptr_d;
  id_t  lock_idx_q;
  logic lock_q, lock_d;
  logic err_q, err_d;
  id_t  sel, head;
  logic any_req, handshake, pop;
  logic fifo_full, fifo_empty;

  // Scan from rr_ptr for the first requester; a stalled address phase keeps
  // its index so the request seen by the slave cannot change before gnt.
  always_comb begin
    int  idx;
    id_t cand;
    idx     = 0;
    cand    = '0;
    sel     = rr_ptr_q;
    any_req = 1'b0;
    if (lock_q) begin
      sel     = lock_idx_q;
      any_req = master_req_i[lock_idx_q].req;
    end else begin
      for (int k = 0; k < NMASTER; k++) begin
        idx = int'(rr_ptr_q) + k;
        if (idx >= NMASTER) idx = idx - NMASTER;
        cand = id_t'(idx);
        if (!any_req && master_req_i[cand].req) begin
          any_req = 1'b1;
          sel     = cand;
        end
      end
    end
  end

  always_comb begin
    slave_req_o     = master_req_i[sel];
    slave_req_o.req = any_req & ~fifo_full;
  end

  assign handshake = slave_req_o.req & slave_resp_i.gnt;
  assign pop       = slave_resp_i.rvalid & ~fifo_empty;
  assign lock_d    = slave_req_o.req & ~slave_resp_i.gnt;
  assign err_d     = err_q | (slave_resp_i.rvalid & fifo_empty);

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (handshake) rr_ptr_d = (sel == id_t'(NMASTER - 1)) ? '0 : sel + id_t'(1);
  end

  always_comb begin
    for (int i = 0; i < NMASTER; i++) begin
      master_resp_o[i].gnt    = handshake && (sel == id_t'(i));
      master_resp_o[i].rvalid = pop && (head == id_t'(i));
      master_resp_o[i].rdata  = slave_resp_i.rdata;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      err_q      <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      lock_q   <= lock_d;
      if (lock_d) lock_idx_q <= sel;
      err_q    <= err_d;
    end
  end

  assign err_o = err_q;

  cb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (IdW)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (handshake),
    .pop_i   (pop),
    .data_i  (sel),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (head),
    .count_o (outstanding_o)
  );

endmodule

// File: tb/tb_cb_obi_rr_arbiter.sv
// Directed bench for cb_obi_rr_arbiter (3 masters, 2 outstanding): a vector
// table for single-master/rotation traffic plus hand-written corner sequences.
module tb_cb_obi_rr_arbiter;
  import obi_pkg::*;

  localparam int NM = 3;

  typedef struct packed {
    logic [2:0]  req;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        exp_sreq;
    logic [1:0]  exp_aidx;
    logic [2:0]  exp_gnt;
    logic [2:0]  exp_rv;
    logic [1:0]  exp_out;
    logic        exp_err;
  } vec_t;

  logic      clk = 1'b0;
  logic      rst_n;
  obi_req_t  master_req  [NM];
  obi_resp_t master_resp [NM];
  obi_req_t  slave_req;
  obi_resp_t slave_resp;
  logic [1:0] outstanding;
  logic      err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cb_obi_rr_arbiter #(.NMASTER(NM), .MAX_OUTSTANDING(2)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .master_req_i  (master_req),
    .master_resp_o (master_resp),
    .slave_req_o   (slave_req),
    .slave_resp_i  (slave_resp),
    .outstanding_o (outstanding),
    .err_o         (err)
  );

  function automatic logic [31:0] addr_of(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h100;
  endfunction

  function automatic vec_t mk(input logic [2:0] req, input logic gnt, input logic rv,
                              input logic [31:0] rdata, input logic sreq,
                              input logic [1:0] aidx, input logic [2:0] egnt,
                              input logic [2:0] erv, input logic [1:0] eout,
                              input logic eerr);
    vec_t v;
    v.req = req; v.gnt = gnt; v.rv = rv; v.rdata = rdata;
    v.exp_sreq = sreq; v.exp_aidx = aidx; v.exp_gnt = egnt;
    v.exp_rv = erv; v.exp_out = eout; v.exp_err = eerr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] req, input logic gnt, input logic rv,
                       input logic [31:0] rdata);
    for (int i = 0; i < NM; i++) begin
      master_req[i].req   = req[i];
      master_req[i].we    = 1'b0;
      master_req[i].be    = 4'hF;
      master_req[i].addr  = addr_of(i);
      master_req[i].wdata = 32'(i);
    end
    slave_resp.gnt    = gnt;
    slave_resp.rvalid = rv;
    slave_resp.rdata  = rdata;
  endtask

  // Drive one cycle's inputs, check the settled outputs mid-cycle, then
  // advance to just after the next rising edge.
  task automatic apply(input string tag, input vec_t v);
    logic [2:0] g, r;
    drive(v.req, v.gnt, v.rv, v.rdata);
    #1;
    for (int i = 0; i < NM; i++) begin
      g[i] = master_resp[i].gnt;
      r[i] = master_resp[i].rvalid;
    end
    check({tag, " sreq"}, 32'(slave_req.req), 32'(v.exp_sreq));
    if (v.exp_sreq) check({tag, " addr"}, slave_req.addr, addr_of(int'(v.exp_aidx)));
    check({tag, " gnt"}, 32'(g), 32'(v.exp_gnt));
    check({tag, " rvalid"}, 32'(r), 32'(v.exp_rv));
    for (int i = 0; i < NM; i++)
      if (v.exp_rv[i]) check({tag, " rdata"}, master_resp[i].rdata, v.rdata);
    check({tag, " outstanding"}, 32'(outstanding), 32'(v.exp_out));
    check({tag, " err"}, 32'(err), 32'(v.exp_err));
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    drive(3'b000, 1'b0, 1'b0, 32'h0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("reset outstanding", 32'(outstanding), 32'd0);
    check("reset err", 32'(err), 32'd0);
    check("reset sreq", 32'(slave_req.req), 32'd0);
    rst_n = 1'b1;
  endtask

  vec_t tbl [13];

  initial begin
    // Single master 1 (gnt at cycle 0, rvalid at cycle 2), then rotation
    // starting from rr_ptr=2 with the FIFO filling and draining.
    tbl[0]  = mk(3'b000, 0, 0, 32'h0,        0, 0, 3'b000, 3'b000, 2'd0, 0);
    tbl[1]  = mk(3'b010, 1, 0, 32'h0,        1, 1, 3'b010, 3'b000, 2'd0, 0);
    tbl[2]  = mk(3'b000, 0, 0, 32'h0,        0, 0, 3'b000, 3'b000, 2'd1, 0);
    tbl[3]  = mk(3'b000, 0, 1, 32'hCAFE0001, 0, 0, 3'b000, 3'b010, 2'd1, 0);
    tbl[4]  = mk(3'b111, 1, 0, 32'h0,        1, 2, 3'b100, 3'b000, 2'd0, 0);
    tbl[5]  = mk(3'b111, 1, 0, 32'h0,        1, 0, 3'b001, 3'b000, 2'd1, 0);
    tbl[6]  = mk(3'b111, 1, 0, 32'h0,        0, 0, 3'b000, 3'b000, 2'd2, 0);
    tbl[7]  = mk(3'b111, 1, 1, 32'h0000000A, 0, 0, 3'b000, 3'b100, 2'd2, 0);
    tbl[8]  = mk(3'b111, 1, 0, 32'h0,        1, 1, 3'b010, 3'b000, 2'd1, 0);
    tbl[9]  = mk(3'b111, 1, 1, 32'h0000000B, 0, 0, 3'b000, 3'b001, 2'd2, 0);
    tbl[10] = mk(3'b111, 1, 1, 32'h0000000C, 1, 2, 3'b100, 3'b010, 2'd1, 0);
    tbl[11] = mk(3'b000, 0, 1, 32'h0000000D, 0, 0, 3'b000, 3'b100, 2'd1, 0);
    tbl[12] = mk(3'b000, 0, 0, 32'h0,        0, 0, 3'b000, 3'b000, 2'd0, 0);

    drive(3'b000, 1'b0, 1'b0, 32'h0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_dut();

    for (int i = 0; i < 13; i++) apply($sformatf("tbl[%0d]", i), tbl[i]);

    // Rotation from reset: 0,1,2,0,1,2 with each rvalid one cycle behind,
    // then the FIFO fills and the slave request drops until an rvalid.
    reset_dut();
    apply("rot0",  mk(3'b111, 1, 0, 32'h0,  1, 0, 3'b001, 3'b000, 2'd0, 0));
    apply("rot1",  mk(3'b111, 1, 1, 32'hB0, 1, 1, 3'b010, 3'b001, 2'd1, 0));
    apply("rot2",  mk(3'b111, 1, 1, 32'hB1, 1, 2, 3'b100, 3'b010, 2'd1, 0));
    apply("rot3",  mk(3'b111, 1, 1, 32'hB2, 1, 0, 3'b001, 3'b100, 2'd1, 0));
    apply("rot4",  mk(3'b111, 1, 1, 32'hB3, 1, 1, 3'b010, 3'b001, 2'd1, 0));
    apply("rot5",  mk(3'b111, 1, 1, 32'hB4, 1, 2, 3'b100, 3'b010, 2'd1, 0));
    apply("rot6",  mk(3'b111, 1, 0, 32'h0,  1, 0, 3'b001, 3'b000, 2'd1, 0));
    apply("rot7",  mk(3'b111, 1, 0, 32'h0,  0, 0, 3'b000, 3'b000, 2'd2, 0));
    apply("rot8",  mk(3'b111, 1, 1, 32'hB5, 0, 0, 3'b000, 3'b100, 2'd2, 0));
    apply("rot9",  mk(3'b111, 1, 0, 32'h0,  1, 1, 3'b010, 3'b000, 2'd1, 0));
    apply("rot10", mk(3'b000, 0, 1, 32'hB6, 0, 0, 3'b000, 3'b001, 2'd2, 0));
    apply("rot11", mk(3'b000, 0, 1, 32'hB7, 0, 0, 3'b000, 3'b010, 2'd1, 0));
    apply("rot12", mk(3'b000, 0, 0, 32'h0,  0, 0, 3'b000, 3'b000, 2'd0, 0));

    // Stall: master 2 selected and stalled for 3 cycles while master 0 joins.
    reset_dut();
    apply("stall0", mk(3'b100, 0, 0, 32'h0,  1, 2, 3'b000, 3'b000, 2'd0, 0));
    apply("stall1", mk(3'b101, 0, 0, 32'h0,  1, 2, 3'b000, 3'b000, 2'd0, 0));
    apply("stall2", mk(3'b101, 0, 0, 32'h0,  1, 2, 3'b000, 3'b000, 2'd0, 0));
    apply("stall3", mk(3'b101, 1, 0, 32'h0,  1, 2, 3'b100, 3'b000, 2'd0, 0));
    apply("stall4", mk(3'b001, 1, 1, 32'hC2, 1, 0, 3'b001, 3'b100, 2'd1, 0));
    apply("stall5", mk(3'b000, 0, 1, 32'hC0, 0, 0, 3'b000, 3'b001, 2'd1, 0));
    apply("stall6", mk(3'b000, 0, 0, 32'h0,  0, 0, 3'b000, 3'b000, 2'd0, 0));

    // Spaced responses: grants 0 then 2, no bypass while full, push+pop.
    reset_dut();
    apply("ooc0",  mk(3'b001, 1, 0, 32'h0,  1, 0, 3'b001, 3'b000, 2'd0, 0));
    apply("ooc1",  mk(3'b100, 1, 0, 32'h0,  1, 2, 3'b100, 3'b000, 2'd1, 0));
    apply("ooc2",  mk(3'b000, 0, 0, 32'h0,  0, 0, 3'b000, 3'b000, 2'd2, 0));
    apply("ooc3",  mk(3'b010, 1, 1, 32'hD0, 0, 0, 3'b000, 3'b001, 2'd2, 0));
    apply("ooc4",  mk(3'b010, 1, 0, 32'h0,  1, 1, 3'b010, 3'b000, 2'd1, 0));
    apply("ooc5",  mk(3'b000, 0, 0, 32'h0,  0, 0, 3'b000, 3'b000, 2'd2, 0));
    apply("ooc6",  mk(3'b000, 0, 0, 32'h0,  0, 0, 3'b000, 3'b000, 2'd2, 0));
    apply("ooc7",  mk(3'b000, 0, 1, 32'hD2, 0, 0, 3'b000, 3'b100, 2'd2, 0));
    apply("ooc8",  mk(3'b001, 1, 1, 32'hD1, 1, 0, 3'b001, 3'b010, 2'd1, 0));
    apply("ooc9",  mk(3'b000, 0, 1, 32'hD3, 0, 0, 3'b000, 3'b001, 2'd1, 0));
    apply("ooc10", mk(3'b000, 0, 0, 32'h0,  0, 0, 3'b000, 3'b000, 2'd0, 0));

    // Protocol error: rvalid with an empty FIFO; err sticks until reset.
    reset_dut();
    apply("perr0", mk(3'b000, 0, 1, 32'hEE, 0, 0, 3'b000, 3'b000, 2'd0, 0));
    for (int i = 0; i < 10; i++)
      apply($sformatf("perr_hold%0d", i), mk(3'b000, 0, 0, 32'h0, 0, 0, 3'b000, 3'b000, 2'd0, 1));
    reset_dut();

    // Reset asserted between edges with two transactions in flight.
    apply("mid0", mk(3'b011, 1, 0, 32'h0, 1, 0, 3'b001, 3'b000, 2'd0, 0));
    apply("mid1", mk(3'b011, 1, 0, 32'h0, 1, 1, 3'b010, 3'b000, 2'd1, 0));
    drive(3'b000, 1'b0, 1'b0, 32'h0);
    #1;
    check("mid pre-reset outstanding", 32'(outstanding), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid async outstanding", 32'(outstanding), 32'd0);
    check("mid async sreq", 32'(slave_req.req), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    apply("mid2", mk(3'b111, 1, 0, 32'h0,  1, 0, 3'b001, 3'b000, 2'd0, 0));
    apply("mid3", mk(3'b111, 0, 0, 32'h0,  1, 1, 3'b000, 3'b000, 2'd1, 0));
    apply("mid4", mk(3'b000, 0, 1, 32'hF0, 0, 0, 3'b000, 3'b001, 2'd1, 0));
    apply("mid5", mk(3'b000, 0, 0, 32'h0,  0, 0, 3'b000, 3'b000, 2'd0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
